// File: rtl/spi_register_port.sv
// -----------------------------------------------------------------------------
// spi_register_port
//
// Bridges an SPI mode-0 host to the synth's parallel register-write port and
// streams the most recent synth sample back to the host over MISO.
// SCK is oversampled by i_Clock, so the whole block lives in one clock domain.
//
// Frame while CS_N is low: addr[15:8], addr[7:0], then one or more data bytes.
// Each data byte produces one single-cycle write strobe; the address
// auto-increments (wrapping at 16'hFFFF) for every further byte of a burst.
//
// Ports:
//   i_Clock               system clock, all state on its rising edge
//   i_Reset               asynchronous active-high reset
//   i_SPI_SCK             SPI clock (async, idles low)
//   i_SPI_CS_N            SPI chip select, active low (async)
//   i_SPI_MOSI            serial data in, MSB first (async)
//   o_SPI_MISO            serial data out, MSB first
//   i_Sample              signed synth output sample
//   i_SampleReady         one-cycle strobe qualifying i_Sample
//   o_RegisterWriteEnable one-cycle write strobe
//   o_RegisterWriteNumber register number (passed through undecoded)
//   o_RegisterWriteValue  register data
// -----------------------------------------------------------------------------
module spi_register_port #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_CS_N,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    input  logic [15:0] i_Sample,
    input  logic        i_SampleReady,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterWriteNumber,
    output logic [7:0]  o_RegisterWriteValue
);

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;

    // Synchronizers
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;

    // Edge detection, registered so every event reaches the FSM in the
    // same cycle as the MOSI bit that goes with it.
    logic sck_prev_q;
    logic cs_prev_q;
    logic sck_rise_q;
    logic sck_fall_q;
    logic cs_rise_q;
    logic cs_fall_q;
    logic mosi_q;

    // Frame state
    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  shift_d;
    logic [15:0] addr_q;
    logic [15:0] miso_sr_q;
    logic [15:0] sample_latch_q;

    // A completed data byte is staged here, then presented on the outputs
    // the following cycle.
    logic        pend_q;
    logic [15:0] pend_num_q;
    logic [7:0]  pend_val_q;

    logic        wr_en_q;
    logic [15:0] wr_num_q;
    logic [7:0]  wr_val_q;

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign shift_d = {shift_q, mosi_q};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            sck_rise_q  <= sck_s & ~sck_prev_q;
            sck_fall_q  <= ~sck_s & sck_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            // cs_prev_q clears on reset, so CS_N already low at release
            // never looks like a falling edge.
            cs_fall_q   <= ~cs_s & cs_prev_q;
            mosi_q      <= mosi_s;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sample_latch_q <= '0;
        end else if (i_SampleReady) begin
            sample_latch_q <= i_Sample;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            miso_sr_q  <= '0;
            pend_q     <= 1'b0;
            pend_num_q <= '0;
            pend_val_q <= '0;
        end else begin
            pend_q <= 1'b0;
            if (cs_rise_q) begin
                // Abort: partial bytes are dropped, MISO returns to 0.
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                miso_sr_q <= '0;
            end else if (state_q == IDLE) begin
                if (cs_fall_q) begin
                    state_q   <= ADDR_HI;
                    bit_cnt_q <= '0;
                    // A sample arriving on the same cycle is newer than the latch.
                    miso_sr_q <= i_SampleReady ? i_Sample : sample_latch_q;
                end
            end else if (!cs_prev_q) begin
                if (sck_fall_q) begin
                    miso_sr_q <= {miso_sr_q[14:0], 1'b0};
                end
                if (sck_rise_q) begin
                    shift_q   <= shift_d[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ADDR_HI: begin
                                addr_q[15:8] <= shift_d;
                                state_q      <= ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_q[7:0] <= shift_d;
                                state_q     <= DATA;
                            end
                            DATA: begin
                                pend_q     <= 1'b1;
                                pend_num_q <= addr_q;
                                pend_val_q <= shift_d;
                                addr_q     <= addr_q + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Output stage: once staged, a write is issued even if CS_N rises now.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_en_q  <= 1'b0;
            wr_num_q <= '0;
            wr_val_q <= '0;
        end else begin
            wr_en_q <= pend_q;
            if (pend_q) begin
                wr_num_q <= pend_num_q;
                wr_val_q <= pend_val_q;
            end
        end
    end

    assign o_RegisterWriteEnable = wr_en_q;
    assign o_RegisterWriteNumber = wr_num_q;
    assign o_RegisterWriteValue  = wr_val_q;
    assign o_SPI_MISO            = miso_sr_q[15];

endmodule

// File: tb/tb_spi_register_port.sv
module tb_spi_register_port;

    localparam int S = 2;   // synchronizer depth
    localparam int H = 8;   // clocks per SCK half period

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [15:0] sample;
    logic        ready;
    logic        wen;
    logic [15:0] wnum;
    logic [7:0]  wval;

    always #5 clk = ~clk;

    spi_register_port #(.SYNC_STAGES(S)) dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_SPI_SCK             (sck),
        .i_SPI_CS_N            (cs_n),
        .i_SPI_MOSI            (mosi),
        .o_SPI_MISO            (miso),
        .i_Sample              (sample),
        .i_SampleReady         (ready),
        .o_RegisterWriteEnable (wen),
        .o_RegisterWriteNumber (wnum),
        .o_RegisterWriteValue  (wval)
    );

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    bit          miso_bits[$];
    int          run_len = 0;
    int          max_run = 0;
    time         strobe_t = 0;
    time         rise_t = 0;
    logic [15:0] latest = 16'h0000;
    logic [7:0]  tx_b [8];

    // Strobe monitor: log every write and the longest run of enable.
    always @(negedge clk) begin
        if (wen) begin
            obs_q.push_back({wnum, wval});
            strobe_t = $time;
            run_len  = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        mosi = b;
        tick(H);
        miso_bits.push_back(miso);
        sck    = 1'b1;
        rise_t = $time;
        tick(H);
        sck = 1'b0;
    endtask

    task automatic cs_release();
        tick(6);
        cs_n = 1'b1;
        tick(12);
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        ready  = 1'b1;
        sample = v;
        tick(1);
        ready  = 1'b0;
        latest = v;
    endtask

    // Reference: whole bytes only; bytes 0/1 are the address, the rest are
    // writes to consecutive addresses modulo 2^16.
    task automatic model_frame(input int nbits);
        int full = nbits / 8;
        int a = (int'(tx_b[0]) << 8) + int'(tx_b[1]);
        for (int i = 2; i < full; i++) begin
            exp_q.push_back({16'(a % 65536), tx_b[i]});
            a = a + 1;
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic compare_miso(input string tag, input int nbits);
        logic [63:0] ov = '0;
        logic [63:0] ev = '0;
        for (int i = 0; i < nbits; i++) begin
            ov = {ov[62:0], miso_bits[i]};
            ev = {ev[62:0], (i < 16) ? latest[15-i] : 1'b0};
        end
        check({tag, "_miso"}, ov, ev);
    endtask

    task automatic frame(input string tag, input int nbits);
        obs_q.delete();
        exp_q.delete();
        miso_bits.delete();
        max_run = 0;
        model_frame(nbits);
        cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) send_bit(tx_b[i/8][7-(i%8)]);
        cs_release();
        compare_writes(tag);
        compare_miso(tag, nbits);
        check({tag, "_idle_miso"}, 64'(miso), 64'(0));
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        ready = 1'b0; sample = 16'h0000;
        tick(3);
        check("rst_wen", 64'(wen), 64'(0));
        check("rst_num", 64'(wnum), 64'(16'h0000));
        check("rst_val", 64'(wval), 64'(8'h00));
        check("rst_miso", 64'(miso), 64'(0));
        rst = 1'b0;
        tick(5);

        // Single write, latency and hold
        tx_b[0] = 8'hC0; tx_b[1] = 8'h05; tx_b[2] = 8'hA5;
        frame("single", 24);
        check("single_strobe_len", 64'(max_run), 64'(1));
        check("single_latency", 64'(strobe_t - rise_t), 64'(10 * (S + 3)));
        check("single_hold_wen", 64'(wen), 64'(0));
        check("single_hold_num", 64'(wnum), 64'(16'hC005));
        check("single_hold_val", 64'(wval), 64'(8'hA5));

        // Burst with address wrap, plus sample readback
        pulse_sample(16'h8001);
        tick(3);
        tx_b[0] = 8'hFF; tx_b[1] = 8'hFF; tx_b[2] = 8'h11; tx_b[3] = 8'h22; tx_b[4] = 8'h33;
        frame("burst", 40);
        check("burst_strobe_len", 64'(max_run), 64'(1));

        // Aborted frame, then a good one
        tx_b[0] = 8'h80; tx_b[1] = 8'h00; tx_b[2] = 8'h01;
        frame("abort", 20);
        frame("after_abort", 24);

        // Readback collision: new sample on the cs_fall processing cycle
        pulse_sample(16'hBEEF);
        tick(3);
        obs_q.delete(); exp_q.delete(); miso_bits.delete();
        cs_n = 1'b0;
        tick(S + 1);
        ready = 1'b1; sample = 16'h1234;
        tick(1);
        ready = 1'b0; latest = 16'h1234;
        tick(4);
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        cs_release();
        compare_writes("collide");
        compare_miso("collide", 16);

        // Async reset during the second data byte of a burst
        tx_b[0] = 8'h12; tx_b[1] = 8'h34; tx_b[2] = 8'h56; tx_b[3] = 8'h78; tx_b[4] = 8'h9A;
        obs_q.delete(); exp_q.delete(); miso_bits.delete();
        exp_q.push_back({16'h1234, 8'h56});
        cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < 28; i++) send_bit(tx_b[i/8][7-(i%8)]);
        rst = 1'b1;
        #1;
        check("midrst_wen", 64'(wen), 64'(0));
        check("midrst_num", 64'(wnum), 64'(0));
        check("midrst_val", 64'(wval), 64'(0));
        check("midrst_miso", 64'(miso), 64'(0));
        tick(2);
        rst = 1'b0;
        latest = 16'h0000;
        for (int i = 28; i < 40; i++) send_bit(tx_b[i/8][7-(i%8)]);
        cs_release();
        compare_writes("midrst");
        check("midrst_hold_num", 64'(wnum), 64'(0));

        // Randomized frames against the reference model
        for (int k = 0; k < 8; k++) begin
            int nbytes;
            int nbits;
            if ($urandom_range(0, 1) == 1) begin
                pulse_sample(16'($urandom));
                tick(3);
            end
            nbytes = $urandom_range(2, 6);
            nbits  = nbytes * 8;
            if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
            for (int j = 0; j < 8; j++) tx_b[j] = 8'($urandom);
            frame("random", nbits);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
